// File: rtl/mac_dot_seq_if.sv
// ---------------------------------------------------------------------------
// mac_dot_seq_if
//
// Purpose : bundles every non-clock/reset signal of the dot-product
//           sequencer. This covers the job handshake, the two operand-RAM
//           read ports, the MAC operand/control side and the result port.
//
// Modports:
//   master - the sequencer's view (drives rd_en/addresses, MAC operands and
//            controls, busy/result/result_valid).
//   slave  - the environment's view (control FSM, operand RAMs and the MAC
//            unit): drives start/len/bases, RAM read data and mac_psum.
//
// Signal summary:
//   start, len, a_base, b_base   job request and its parameters
//   rd_en, a_addr, b_addr        read strobe/addresses to both RAMs
//   a_rdata, b_rdata             RAM data, valid the cycle after rd_en
//   mac_a, mac_b                 MAC operands
//   mac_clear, mac_next          MAC accumulator clear / accumulate enable
//   mac_psum                     MAC accumulator value (65 bit)
//   busy, result, result_valid   job status and captured dot product
// ---------------------------------------------------------------------------
interface mac_dot_seq_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;

    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       a_rdata;
    logic [31:0]       b_rdata;

    logic [31:0]       mac_a;
    logic [31:0]       mac_b;
    logic              mac_clear;
    logic              mac_next;
    logic [64:0]       mac_psum;

    logic              busy;
    logic [64:0]       result;
    logic              result_valid;

    modport master (
        input  start, len, a_base, b_base,
        input  a_rdata, b_rdata, mac_psum,
        output rd_en, a_addr, b_addr,
        output mac_a, mac_b, mac_clear, mac_next,
        output busy, result, result_valid
    );

    modport slave (
        output start, len, a_base, b_base,
        output a_rdata, b_rdata, mac_psum,
        input  rd_en, a_addr, b_addr,
        input  mac_a, mac_b, mac_clear, mac_next,
        input  busy, result, result_valid
    );
endinterface

// File: rtl/mac_dot_seq.sv
// ---------------------------------------------------------------------------
// mac_dot_seq
//
// Purpose : dot-product sequencer in front of a 32x32 multiply-accumulate
//           unit. When a job starts, it does the following:
//             - streams N operand pairs out of two synchronous RAMs;
//             - feeds each pair to the MAC;
//             - clears the accumulator at job start;
//             - times mac_next to the MAC's two-stage operand/multiply
//               pipeline;
//             - captures the final 65-bit mac_psum as the job result.
//
// Ports:
//   clk    in  clock, all state changes on the rising edge
//   reset  in  asynchronous, active-high reset; aborts any job in flight
//   bus    master modport of mac_dot_seq_if (handshake, RAM, MAC, result)
//
// Cycle timeline, start sampled in cycle 0 (N > 0):
//   rd_en       cycles 1..N
//   mac_a/b     cycles 2..N+1   (RAM output, forced to 0 when not valid)
//   mac_next    cycles 4..N+3
//   CAPTURE     cycle  N+4,  result_valid in cycle N+5
//   busy        cycles 1..N+4
// For N = 0 the sequence is:
//   cycle 1  mac_clear pulses (FLUSH);
//   cycle 2  CAPTURE;
//   cycle 3  result_valid.
// ---------------------------------------------------------------------------
module mac_dot_seq #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic          clk,
    input  logic          reset,
    mac_dot_seq_if.master bus
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    // Largest legal job: one pass over the whole operand RAM.
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    // DRAIN lasts three cycles; the counter is loaded with 2 and
    // counts down to 0.
    localparam logic [1:0] DRAIN_LOAD = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]        state_q,  state_d;
    logic [LEN_W-1:0]  remain_q, remain_d;   // issues still to perform
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic              first_q,  first_d;    // first ISSUE cycle of the job
    logic [1:0]        drain_q,  drain_d;

    // rd_pipe_q[k] is rd_en delayed by k+1 cycles. Each tap has one role:
    //   tap 0 - the RAM data is valid this cycle;
    //   tap 1 - the operands sit in the MAC operand register;
    //   tap 2 - the product sits in the multiplier register, so this
    //           tap drives mac_next.
    logic [2:0]        rd_pipe_q, rd_pipe_d;

    logic [64:0]       result_q,       result_d;
    logic              result_valid_q, result_valid_d;

    // -----------------------------------------------------------------------
    // Decoded controls
    // -----------------------------------------------------------------------
    logic              rd_en_w;
    logic              clear_w;
    logic [LEN_W-1:0]  len_clamped;

    assign len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

    assign rd_en_w = (state_q == S_ISSUE);

    // The accumulator is cleared in the first ISSUE cycle. The first
    // mac_next comes three cycles later, so the clear always lands
    // before any accumulation. FLUSH gives the same clear to empty jobs.
    assign clear_w = (state_q == S_FLUSH) || ((state_q == S_ISSUE) && first_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        remain_d       = remain_q;
        a_addr_d       = a_addr_q;
        b_addr_d       = b_addr_q;
        first_d        = first_q;
        drain_d        = drain_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        rd_pipe_d      = {rd_pipe_q[1:0], rd_en_w};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_addr_d = bus.a_base;
                    b_addr_d = bus.b_base;
                    first_d  = 1'b1;
                    remain_d = len_clamped;
                    if (len_clamped == '0) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                first_d = 1'b0;
                if (remain_q == LEN_W'(1)) begin
                    state_d  = S_DRAIN;
                    drain_d  = DRAIN_LOAD;
                    remain_d = '0;
                end else begin
                    remain_d = remain_q - LEN_W'(1);
                    // Addresses wrap naturally at 2^ADDR_W.
                    a_addr_d = a_addr_q + ADDR_W'(1);
                    b_addr_d = b_addr_q + ADDR_W'(1);
                end
            end

            S_DRAIN: begin
                // Covers the operand register, the multiplier register and
                // the final accumulate, so mac_psum is final in CAPTURE.
                if (drain_q == 2'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end

            S_FLUSH: begin
                first_d = 1'b0;
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                result_d       = bus.mac_psum;
                result_valid_d = 1'b1;
                state_d        = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            remain_q       <= '0;
            a_addr_q       <= '0;
            b_addr_q       <= '0;
            first_q        <= 1'b0;
            drain_q        <= 2'd0;
            rd_pipe_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            remain_q       <= remain_d;
            a_addr_q       <= a_addr_d;
            b_addr_q       <= b_addr_d;
            first_q        <= first_d;
            drain_q        <= drain_d;
            rd_pipe_q      <= rd_pipe_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.rd_en        = rd_en_w;
    assign bus.a_addr       = a_addr_q;
    assign bus.b_addr       = b_addr_q;

    // The RAM output register is the pipeline stage here. The data is
    // gated so that stale RAM output never reaches the MAC.
    assign bus.mac_a        = rd_pipe_q[0] ? bus.a_rdata : 32'd0;
    assign bus.mac_b        = rd_pipe_q[0] ? bus.b_rdata : 32'd0;

    assign bus.mac_clear    = clear_w;
    assign bus.mac_next     = rd_pipe_q[2];

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_seq
//
// Surrounds mac_dot_seq with two synchronous operand RAMs and a behavioural
// two-stage MAC. It runs two groups of jobs:
//   - a table of directed jobs;
//   - hand-written multi-cycle sequences (start while busy, back-to-back
//     start, reset mid-job) and randomized jobs.
// Expected results come from the table constants, or from a plain
// sum-of-products over the RAM contents.
// ---------------------------------------------------------------------------
module tb_mac_dot_seq;

    localparam int AW    = 8;
    localparam int LW    = 9;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_dot_seq_if #(.ADDR_W(AW), .LEN_W(LW)) bus_if ();

    mac_dot_seq #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ---------------- operand RAMs (synchronous read) ----------------------
    logic [31:0] ram_a [DEPTH];
    logic [31:0] ram_b [DEPTH];

    always @(posedge clk) begin
        if (bus_if.rd_en) begin
            bus_if.a_rdata <= ram_a[bus_if.a_addr];
            bus_if.b_rdata <= ram_b[bus_if.b_addr];
        end
    end

    // ---------------- behavioural MAC: operand reg -> product reg -> acc ---
    logic [31:0] mac_ra = '0;
    logic [31:0] mac_rb = '0;
    logic [63:0] mac_prod = '0;
    logic [64:0] mac_acc = '0;

    always @(posedge clk) begin
        mac_ra   <= bus_if.mac_a;
        mac_rb   <= bus_if.mac_b;
        mac_prod <= {32'd0, mac_ra} * {32'd0, mac_rb};
        if (bus_if.mac_clear)
            mac_acc <= '0;
        else if (bus_if.mac_next)
            mac_acc <= mac_acc + {1'b0, mac_prod};
    end
    assign bus_if.mac_psum = mac_acc;

    // ---------------- bookkeeping -----------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain sum of products over the addressed RAM words.
    function automatic logic [64:0] ref_dot(input int n, input logic [7:0] ab, input logic [7:0] bb);
        logic [64:0] s;
        int          neff;
        logic [7:0]  ia;
        logic [7:0]  ib;
        s    = '0;
        neff = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < neff; i++) begin
            ia = ab + 8'(i);
            ib = bb + 8'(i);
            s  = s + 65'(ram_a[ia]) * 65'(ram_b[ib]);
        end
        return s;
    endfunction

    task automatic randomize_rams();
        for (int i = 0; i < DEPTH; i++) begin
            ram_a[i] = $urandom;
            ram_b[i] = $urandom;
        end
    endtask

    // Parameters for a job chained onto the result_valid cycle.
    int         chain_n;
    logic [7:0] chain_ab;
    logic [7:0] chain_bb;

    // Runs one job and checks its whole cycle timeline.
    //   pre_started - start was already driven in the current cycle, which
    //                 is this job's cycle 0.
    //   chain       - drive start for the chained job in the
    //                 result_valid cycle.
    //   poke_busy   - pulse start with other parameters while busy.
    task automatic run_job(input string tag, input int n, input logic [7:0] ab, input logic [7:0] bb,
                           input logic [64:0] exp, input bit pre_started, input bit chain,
                           input bit poke_busy);
        int          neff;
        int          last_busy;
        int          rv_cyc;
        int          stop;
        int          rd_cnt;
        int          win_err;
        int          nx_cnt;
        int          nx_first;
        int          nx_last;
        int          clr_cnt;
        int          clr_cyc;
        int          busy_err;
        int          rv_cnt;
        int          rv_at;
        logic [64:0] rv_res;
        logic [7:0]  ea;
        logic [7:0]  eb;

        neff      = (n > DEPTH) ? DEPTH : n;
        last_busy = (neff == 0) ? 2 : neff + 4;
        rv_cyc    = last_busy + 1;
        stop      = chain ? rv_cyc : rv_cyc + 3;
        rd_cnt = 0; win_err = 0; nx_cnt = 0; nx_first = -1; nx_last = -1;
        clr_cnt = 0; clr_cyc = -1; busy_err = 0; rv_cnt = 0; rv_at = -1; rv_res = '0;

        if (!pre_started) begin
            @(negedge clk);
            bus_if.start  = 1'b1;
            bus_if.len    = LW'(n);
            bus_if.a_base = ab;
            bus_if.b_base = bb;
        end

        for (int c = 1; c <= stop; c++) begin
            @(negedge clk);
            if (c == 1) bus_if.start = 1'b0;
            if (poke_busy && c == 2) begin
                bus_if.start  = 1'b1;
                bus_if.len    = LW'(5);
                bus_if.a_base = ab + 8'd100;
            end
            if (poke_busy && c == 3) bus_if.start = 1'b0;

            if (bus_if.rd_en) begin
                rd_cnt++;
                ea = ab + 8'(c - 1);
                eb = bb + 8'(c - 1);
                if (c > neff || bus_if.a_addr !== ea || bus_if.b_addr !== eb) win_err++;
            end
            if (bus_if.mac_next) begin
                nx_cnt++;
                if (nx_first < 0) nx_first = c;
                nx_last = c;
            end
            if (bus_if.mac_clear) begin
                clr_cnt++;
                if (clr_cyc < 0) clr_cyc = c;
            end
            if (bus_if.busy !== (c <= last_busy)) busy_err++;
            if (bus_if.result_valid) begin
                rv_cnt++;
                if (rv_at < 0) begin
                    rv_at  = c;
                    rv_res = bus_if.result;
                end
            end
            if (chain && c == rv_cyc) begin
                bus_if.start  = 1'b1;
                bus_if.len    = LW'(chain_n);
                bus_if.a_base = chain_ab;
                bus_if.b_base = chain_bb;
            end
        end

        check({tag, " rd_en count"}, 65'(rd_cnt), 65'(neff));
        check({tag, " rd addr/window errs"}, 65'(win_err), 65'd0);
        check({tag, " mac_next count"}, 65'(nx_cnt), 65'(neff));
        if (neff > 0) begin
            check({tag, " first mac_next cycle"}, 65'(nx_first), 65'd4);
            check({tag, " last mac_next cycle"}, 65'(nx_last), 65'(neff + 3));
        end
        check({tag, " mac_clear count"}, 65'(clr_cnt), 65'd1);
        check({tag, " mac_clear cycle"}, 65'(clr_cyc), 65'd1);
        check({tag, " busy errs"}, 65'(busy_err), 65'd0);
        check({tag, " result_valid count"}, 65'(rv_cnt), 65'd1);
        check({tag, " result_valid cycle"}, 65'(rv_at), 65'(rv_cyc));
        check({tag, " result"}, rv_res, exp);
        if (!chain) check({tag, " result hold"}, bus_if.result, exp);
        $display("job %s: N=%0d a_base=%0d b_base=%0d result=0x%0h expected=0x%0h",
                 tag, n, ab, bb, rv_res, exp);
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        string             name;
        int                n;
        logic [7:0]        ab;
        logic [7:0]        bb;
        logic [0:3][31:0]  av;
        logic [0:3][31:0]  bv;
        logic [64:0]       exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [64:0] e1;
        logic [64:0] e2;
        int          busy_seen;
        int          n_rand;

        vecs[0] = '{"n3_small", 3, 8'd0, 8'd0,
                    {32'd1, 32'd2, 32'd3, 32'd0}, {32'd4, 32'd5, 32'd6, 32'd0}, 65'd32};
        vecs[1] = '{"n4_ones", 4, 8'd16, 8'd32,
                    {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 65'h3_FFFF_FFF8_0000_0004};
        vecs[2] = '{"n3_ones", 3, 8'd16, 8'd32,
                    {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 65'h2_FFFF_FFFA_0000_0003};
        vecs[3] = '{"n0", 0, 8'd7, 8'd9,
                    {4{32'd0}}, {4{32'd0}}, 65'd0};
        vecs[4] = '{"wrap254", 4, 8'd254, 8'd10,
                    {32'd7, 32'd8, 32'd9, 32'd10}, {32'd1, 32'd1, 32'd2, 32'd3}, 65'd63};

        bus_if.start  = 1'b0;
        bus_if.len    = '0;
        bus_if.a_base = '0;
        bus_if.b_base = '0;
        randomize_rams();

        // ---- reset state ----
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy",         65'(bus_if.busy),         65'd0);
        check("reset rd_en",        65'(bus_if.rd_en),        65'd0);
        check("reset mac_next",     65'(bus_if.mac_next),     65'd0);
        check("reset mac_clear",    65'(bus_if.mac_clear),    65'd0);
        check("reset result_valid", 65'(bus_if.result_valid), 65'd0);
        check("reset result",       bus_if.result,            65'd0);
        check("reset a_addr",       65'(bus_if.a_addr),       65'd0);
        check("reset mac_a",        65'(bus_if.mac_a),        65'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---- table-driven directed jobs ----
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                ram_a[8'(vecs[i].ab + 8'(k))] = vecs[i].av[k];
                ram_b[8'(vecs[i].bb + 8'(k))] = vecs[i].bv[k];
            end
            run_job(vecs[i].name, vecs[i].n, vecs[i].ab, vecs[i].bb, vecs[i].exp, 1'b0, 1'b0, 1'b0);
        end

        // ---- start pulsed while busy is ignored ----
        randomize_rams();
        e1 = ref_dot(10, 8'd40, 8'd90);
        run_job("busy_poke", 10, 8'd40, 8'd90, e1, 1'b0, 1'b0, 1'b1);

        // ---- back-to-back start on the result_valid cycle ----
        chain_n  = 6;
        chain_ab = 8'd200;
        chain_bb = 8'd3;
        e1 = ref_dot(5, 8'd60, 8'd70);
        e2 = ref_dot(chain_n, chain_ab, chain_bb);
        run_job("chain_1", 5, 8'd60, 8'd70, e1, 1'b0, 1'b1, 1'b0);
        run_job("chain_2", chain_n, chain_ab, chain_bb, e2, 1'b1, 1'b0, 1'b0);

        // ---- reset in cycle 3 of an N=8 job ----
        @(negedge clk);
        bus_if.start  = 1'b1;
        bus_if.len    = LW'(8);
        bus_if.a_base = 8'd20;
        bus_if.b_base = 8'd40;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst busy",      65'(bus_if.busy),      65'd0);
        check("midrst rd_en",     65'(bus_if.rd_en),     65'd0);
        check("midrst mac_next",  65'(bus_if.mac_next),  65'd0);
        check("midrst mac_clear", 65'(bus_if.mac_clear), 65'd0);
        check("midrst mac_a",     65'(bus_if.mac_a),     65'd0);
        check("midrst mac_b",     65'(bus_if.mac_b),     65'd0);
        check("midrst a_addr",    65'(bus_if.a_addr),    65'd0);
        check("midrst result",    bus_if.result,         65'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        busy_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus_if.rd_en || bus_if.mac_next || bus_if.busy) busy_seen++;
        end
        check("post-reset activity", 65'(busy_seen), 65'd0);
        e1 = ref_dot(7, 8'd20, 8'd40);
        run_job("after_reset", 7, 8'd20, 8'd40, e1, 1'b0, 1'b0, 1'b0);

        // ---- randomized jobs ----
        for (int j = 0; j < 8; j++) begin
            logic [7:0] rab;
            logic [7:0] rbb;
            randomize_rams();
            rab    = 8'($urandom_range(0, 255));
            rbb    = 8'($urandom_range(0, 255));
            n_rand = (j == 3) ? 300 : ((j == 5) ? 0 : int'($urandom_range(1, 40)));
            e1     = ref_dot(n_rand, rab, rbb);
            run_job($sformatf("rand%0d", j), n_rand, rab, rbb, e1, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
